// File: rtl/regfile_pkg.sv
// Shared types and helpers for the banked register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   clr_state_t : bulk-clear sequencer states
//   idx()       : linear register index from {bank, addr}
package regfile_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_t;

    // Linear index = {bank, addr}; aw is the per-bank address width.
    function automatic int unsigned idx(input int unsigned bank,
                                        input int unsigned addr,
                                        input int unsigned aw);
        return (bank << aw) | addr;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every register index once, one per cycle.
// Latency: NREG cycles busy after the request, then a one-cycle done pulse.
// Backpressure: none; user writes arriving while busy are refused and flagged one cycle later.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clr_req_i    : clear request, honoured only in CLR_IDLE
//   wr_req_i     : user write attempt (valid bank) this cycle
//   clr_busy_o   : sequence running
//   clr_done_o   : one-cycle pulse after the last register is cleared
//   wr_drop_o    : registered pulse, a user write was refused while busy
//   clr_we_o     : clear write strobe for the storage array
//   clr_idx_o    : register index being cleared
//   wr_allow_o   : user writes may commit this cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = 16,
    parameter int IW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req_i,
    input  logic          wr_req_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic          wr_drop_o,
    output logic          clr_we_o,
    output logic [IW-1:0] clr_idx_o,
    output logic          wr_allow_o
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

    clr_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          drop_q, drop_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drop_d  = (state_q == CLR_RUN) && wr_req_i;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req_i) begin
                    state_d = CLR_RUN;
                    idx_d   = '0;
                end
            end
            CLR_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = CLR_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // A request arriving here is dropped, not queued.
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    // Output logic (Moore, except the registered drop flag)
    always_comb begin
        clr_busy_o = (state_q == CLR_RUN);
        clr_done_o = (state_q == CLR_DONE);
        clr_we_o   = (state_q == CLR_RUN);
        clr_idx_o  = idx_q;
        wr_allow_o = (state_q != CLR_RUN);
        wr_drop_o  = drop_q;
    end

endmodule

// File: rtl/banked_reg_file.sv
// Banked register file: NBANK x 2**AW registers of DW bits with a sequenced bulk clear.
// Latency: reads combinational; a write is visible the next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; writes during a clear are discarded and reported on wr_drop.
//
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding on ports A, B and r1).
//
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   reg_write, wr_bank/addr/data : write port
//   rd_bank_a, rd_addr_a -> data_out_a : read port A, any bank
//   rd_addr_b -> data_out_b   : read port B, bank 0
//   r1                        : continuous tap of bank 0 register 1
//   clr_req -> clr_busy, clr_done : bulk-clear handshake
//   wr_drop                   : pulse when a write was refused during clear
module banked_reg_file
    import regfile_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int AW    = 3,
    parameter  int NBANK = 2,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_write,
    input  logic [BW-1:0] wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [BW-1:0] rd_bank_a,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    input  logic          clr_req,
    output logic [DW-1:0] data_out_a,
    output logic [DW-1:0] data_out_b,
    output logic [DW-1:0] r1,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam int NREG = NBANK << AW;
    localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [IW-1:0] R1_IDX = IW'(1);

    logic [DW-1:0] mem_q [NREG];

    logic [IW-1:0] lin_a, lin_b, lin_w;
    logic          bank_ok_a, bank_ok_w;
    logic          wr_allow, user_we;
    logic          clr_we;
    logic [IW-1:0] clr_idx;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] stored_a, stored_b, stored_r1;

    assign lin_a = IW'(idx(32'(rd_bank_a), 32'(rd_addr_a), AW));
    assign lin_b = IW'(idx(0, 32'(rd_addr_b), AW));
    assign lin_w = IW'(idx(32'(wr_bank), 32'(wr_addr), AW));

    // Only meaningful when NBANK is not a power of two.
    assign bank_ok_a = (32'(rd_bank_a) < 32'(NBANK));
    assign bank_ok_w = (32'(wr_bank)   < 32'(NBANK));

    // Writes to a nonexistent bank vanish silently and never raise wr_drop.
    assign user_we = reg_write && bank_ok_w && wr_allow;

    regfile_clear_fsm #(
        .NREG (NREG),
        .IW   (IW)
    ) u_clr_fsm (
        .clk        (clk),
        .reset      (reset),
        .clr_req_i  (clr_req),
        .wr_req_i   (reg_write && bank_ok_w),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .wr_drop_o  (wr_drop),
        .clr_we_o   (clr_we),
        .clr_idx_o  (clr_idx),
        .wr_allow_o (wr_allow)
    );

    // Single write port: the clear sequencer owns it while running, the user otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = lin_w;
        mem_wdata = wr_data;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = '0;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign stored_a  = bank_ok_a ? mem_q[lin_a] : '0;
    assign stored_b  = mem_q[lin_b];
    assign stored_r1 = mem_q[R1_IDX];

`ifdef REGFILE_BYPASS_EN
    // user_we is already low during a clear, so nothing is forwarded then.
    assign data_out_a = (user_we && bank_ok_a && (lin_a == lin_w)) ? wr_data : stored_a;
    assign data_out_b = (user_we && (lin_b == lin_w))               ? wr_data : stored_b;
    assign r1         = (user_we && (lin_w == R1_IDX))              ? wr_data : stored_r1;
`else
    assign data_out_a = stored_a;
    assign data_out_b = stored_b;
    assign r1         = stored_r1;
`endif

endmodule

// File: tb/tb_banked_reg_file.sv
module tb_banked_reg_file;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reg_write = 1'b0;
    logic [0:0]    wr_bank = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [0:0]    rd_bank_a = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          clr_req = 1'b0;
    logic [DW-1:0] data_out_a, data_out_b, r1;
    logic          clr_busy, clr_done, wr_drop;

    int checks = 0;
    int passes = 0;

    // Reference contents, index = bank*8 + addr
    logic [7:0] model [NREG];

    always #5 clk = ~clk;

    banked_reg_file #(.DW(8), .AW(3), .NBANK(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_bank_a  (rd_bank_a),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .clr_req    (clr_req),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .r1         (r1),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_drop    (wr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int a, input logic [7:0] d);
        wr_bank   = 1'(b);
        wr_addr   = 3'(a);
        wr_data   = d;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        model[b * 8 + a] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NREG; i++) begin
            wr(i / 8, i % 8, 8'($urandom_range(1, 255)));
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    task automatic read_chk_all(input string tag);
        for (int i = 0; i < NREG; i++) begin
            rd_bank_a = 1'(i / 8);
            rd_addr_a = 3'(i % 8);
            rd_addr_b = 3'(i % 8);
            #1;
            chk({tag, "_a"}, 32'(data_out_a), 32'(model[i]));
            if (i < 8) chk({tag, "_b"}, 32'(data_out_b), 32'(model[i]));
        end
        chk({tag, "_r1"}, 32'(r1), 32'(model[1]));
    endtask

    task automatic start_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    // Runs until busy drops (bounded); start = busy cycles already elapsed.
    task automatic wait_clear(input string tag, input int start);
        int cnt;
        cnt = start;
        while (clr_busy && cnt < 64) begin
            cnt++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(NREG));
        chk({tag, "_done_pulse"}, 32'(clr_done), 32'd1);
        tick();
        chk({tag, "_done_low"}, 32'(clr_done), 32'd0);
        chk({tag, "_busy_low"}, 32'(clr_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int b, a, j;
        model_zero();
        #12 reset = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        read_chk_all("rst");

        // Basic write/read
        @(negedge clk);
        wr(1, 3, 8'hA5);
        rd_bank_a = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #1;
        chk("basic_a", 32'(data_out_a), 32'hA5);
        chk("basic_b", 32'(data_out_b), 32'h00);

        // R1 tap
        wr(0, 1, 8'h3C);
        chk("r1_set", 32'(r1), 32'h3C);
        wr(1, 1, 8'h99);
        chk("r1_other_bank", 32'(r1), 32'h3C);

        // Random write/read traffic
        for (int n = 0; n < 60; n++) begin
            b = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 7));
            wr(b, a, 8'($urandom));
            j = int'($urandom_range(0, NREG - 1));
            rd_bank_a = 1'(j / 8);
            rd_addr_a = 3'(j % 8);
            rd_addr_b = 3'(j % 8);
            #1;
            chk("rand_a", 32'(data_out_a), 32'(model[j]));
            chk("rand_b", 32'(data_out_b), 32'(model[j % 8]));
            chk("rand_r1", 32'(r1), 32'(model[1]));
        end

        // Bulk clear, with a partial-clear read at the midpoint
        fill_random();
        start_clear();
        chk("clr_busy_start", 32'(clr_busy), 32'd1);
        cnt = 0;
        while (clr_busy && cnt < 64) begin
            if (cnt == 8) begin
                rd_bank_a = 1'b0; rd_addr_a = 3'd7;
                #1;
                chk("clr_partial_done", 32'(data_out_a), 32'h00);
                rd_bank_a = 1'b1; rd_addr_a = 3'd0;
                #1;
                chk("clr_partial_pending", 32'(data_out_a), 32'(model[8]));
            end
            cnt++;
            tick();
        end
        chk("clr_busy_cycles", 32'(cnt), 32'(NREG));
        chk("clr_done_pulse", 32'(clr_done), 32'd1);
        tick();
        chk("clr_done_low", 32'(clr_done), 32'd0);
        model_zero();
        read_chk_all("clr_after");

        // Write collision in the fifth clear cycle (index 2 is already cleared)
        fill_random();
        start_clear();
        repeat (4) tick();
        wr_bank = 1'b0; wr_addr = 3'd2; wr_data = 8'hFF; reg_write = 1'b1;
        chk("coll_drop_before", 32'(wr_drop), 32'd0);
        tick();
        reg_write = 1'b0;
        chk("coll_drop_pulse", 32'(wr_drop), 32'd1);
        tick();
        chk("coll_drop_once", 32'(wr_drop), 32'd0);
        wait_clear("coll", 6);
        model_zero();
        read_chk_all("coll_after");

        // Request and write together in IDLE: write lands, then is cleared
        wr_bank = 1'b1; wr_addr = 3'd5; wr_data = 8'h77;
        reg_write = 1'b1; clr_req = 1'b1;
        tick();
        reg_write = 1'b0; clr_req = 1'b0;
        rd_bank_a = 1'b1; rd_addr_a = 3'd5;
        #1;
        chk("reqwr_landed", 32'(data_out_a), 32'h77);
        wait_clear("reqwr", 0);
        read_chk_all("reqwr_after");

        // Reset during clear cycle 7
        fill_random();
        start_clear();
        repeat (6) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_done", 32'(clr_done), 32'd0);
        model_zero();
        read_chk_all("abort");
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("abort_no_done", 32'(clr_done), 32'd0);
        start_clear();
        chk("abort_restart_busy", 32'(clr_busy), 32'd1);
        wait_clear("abort_restart", 0);

        // Same-cycle read of a location being written
        wr(0, 2, 8'h11);
        wr_bank = 1'b0; wr_addr = 3'd2; wr_data = 8'h5A; reg_write = 1'b1;
        rd_addr_b = 3'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", 32'(data_out_b), 32'h5A);
`else
        chk("nobypass_same_cycle", 32'(data_out_b), 32'h11);
`endif
        tick();
        reg_write = 1'b0;
        model[2] = 8'h5A;
        chk("bypass_next_cycle", 32'(data_out_b), 32'h5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
